// File: rtl/blit_pkg.sv
// Shared types and defaults for the column-serial piece blitter.
// Provides blit_mode_t, FSM state type, default geometry and cell indexing.
package blit_pkg;

  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;
  localparam int PIECE_N_DEF = 4;
  localparam int COORD_W_DEF = 6;

  // Encoding 3 is not a distinct operation; it behaves as COLLIDE.
  typedef enum logic [1:0] {
    MODE_OVERLAY     = 2'd0,
    MODE_ERASE       = 2'd1,
    MODE_COLLIDE     = 2'd2,
    MODE_COLLIDE_ALT = 2'd3
  } blit_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Column-major board packing: bit x*h + y.
  function automatic int cell_index(input int x, input int y, input int h);
    return x * h + y;
  endfunction

endpackage

// File: rtl/blit_column.sv
// Combinational blit of one piece column into one board column.
// Ports: piece_col, bx, y, board_col, mode in; new_col, col_hit out.
module blit_column
  import blit_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int PIECE_N = PIECE_N_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic [PIECE_N-1:0]        piece_col,
  input  logic signed [COORD_W:0]   bx,
  input  logic signed [COORD_W-1:0] y,
  input  logic [BOARD_H-1:0]        board_col,
  input  blit_mode_t                mode,
  output logic [BOARD_H-1:0]        new_col,
  output logic                      col_hit
);

  localparam int YW = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;

  logic                    on_x;
  logic signed [COORD_W:0] by;
  int                      by_i;

  always_comb begin
    new_col = board_col;
    col_hit = 1'b0;
    by      = '0;
    by_i    = 0;
    on_x    = (int'(bx) >= 0) && (int'(bx) < BOARD_W);
    for (int dy = 0; dy < PIECE_N; dy++) begin
      by   = {y[COORD_W-1], y} + (COORD_W+1)'(dy);
      by_i = int'(by);
      // Rows above the board are the spawn zone: ignored entirely.
      if (piece_col[dy] && by_i >= 0) begin
        if (!on_x || by_i >= BOARD_H) begin
          col_hit = 1'b1;
        end else begin
          if (board_col[by[YW-1:0]]) col_hit = 1'b1;
          unique case (mode)
            MODE_OVERLAY: new_col[by[YW-1:0]] = 1'b1;
            MODE_ERASE:   new_col[by[YW-1:0]] = 1'b0;
            default:      ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/piece_blit_engine.sv
// Column-serial overlay/erase/collide of an NxN piece onto a WxH board.
// Ports: clk, reset, in_* request (valid/ready), out_* result, busy.
module piece_blit_engine
  import blit_pkg::*;
#(
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int PIECE_N = PIECE_N_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_mode,
  input  logic [BOARD_W*BOARD_H-1:0]   in_board,
  input  logic [PIECE_N*PIECE_N-1:0]   in_piece,
  input  logic [COORD_W-1:0]           in_x,
  input  logic [COORD_W-1:0]           in_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BOARD_W*BOARD_H-1:0]   out_board,
  output logic                         out_collision,
  output logic                         busy
);

  localparam int CW = $clog2(PIECE_N + 1);
  localparam int PW = (PIECE_N > 1) ? $clog2(PIECE_N) : 1;
  localparam int XW = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;

  state_t                       state;
  logic [CW-1:0]                col;
  logic [BOARD_H-1:0]           work [BOARD_W];
  logic [BOARD_H-1:0]           in_cols [BOARD_W];
  logic [BOARD_W*BOARD_H-1:0]   work_flat;
  logic [PIECE_N*PIECE_N-1:0]   lat_piece;
  logic [PIECE_N-1:0]           piece_cols [PIECE_N];
  logic signed [COORD_W-1:0]    lat_x;
  logic signed [COORD_W-1:0]    lat_y;
  blit_mode_t                   lat_mode;
  logic                         hit;

  logic signed [COORD_W:0]      bx;
  logic                         on_x;
  logic [XW-1:0]                bx_sel;
  logic [BOARD_H-1:0]           cur_col;
  logic [BOARD_H-1:0]           new_col;
  logic                         col_hit;

  for (genvar c = 0; c < BOARD_W; c++) begin : g_cols
    assign in_cols[c] =
      in_board[cell_index(c, 0, BOARD_H) +: BOARD_H];
    assign work_flat[cell_index(c, 0, BOARD_H) +: BOARD_H] =
      work[c];
  end

  for (genvar p = 0; p < PIECE_N; p++) begin : g_piece
    assign piece_cols[p] = lat_piece[p*PIECE_N +: PIECE_N];
  end

  // Signed sum one bit wider than the coordinate: no wrap-around.
  assign bx = {lat_x[COORD_W-1], lat_x} + (COORD_W+1)'(col);
  assign on_x = (int'(bx) >= 0) && (int'(bx) < BOARD_W);
  assign bx_sel = on_x ? bx[XW-1:0] : '0;
  assign cur_col = work[bx_sel];

  blit_column #(
    .BOARD_W (BOARD_W),
    .BOARD_H (BOARD_H),
    .PIECE_N (PIECE_N),
    .COORD_W (COORD_W)
  ) u_col (
    .piece_col (piece_cols[col[PW-1:0]]),
    .bx        (bx),
    .y         (lat_y),
    .board_col (cur_col),
    .mode      (lat_mode),
    .new_col   (new_col),
    .col_hit   (col_hit)
  );

  assign in_ready  = (state == S_IDLE) && !reset;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      col           <= '0;
      lat_piece     <= '0;
      lat_x         <= '0;
      lat_y         <= '0;
      lat_mode      <= MODE_OVERLAY;
      hit           <= 1'b0;
      out_board     <= '0;
      out_collision <= 1'b0;
      for (int c = 0; c < BOARD_W; c++) work[c] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            work      <= in_cols;
            lat_piece <= in_piece;
            lat_x     <= in_x;
            lat_y     <= in_y;
            lat_mode  <= blit_mode_t'(in_mode);
            hit       <= 1'b0;
            col       <= '0;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Extra step at col==PIECE_N publishes the finished board.
          if (col == CW'(PIECE_N)) begin
            out_board     <= work_flat;
            out_collision <= hit;
            state         <= S_DONE;
          end else begin
            if (on_x) work[bx_sel] <= new_col;
            hit <= hit | col_hit;
            col <= col + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_blit_engine.sv
// Scoreboard bench for piece_blit_engine: random and directed requests.
// Driver pushes model results; monitor pops and checks on out_valid.
module tb_piece_blit_engine;

  localparam int W = 10;
  localparam int H = 20;
  localparam int N = 4;
  localparam int LAT = N + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [W*H-1:0]   in_board;
  logic [N*N-1:0]   in_piece;
  logic [5:0]       in_x;
  logic [5:0]       in_y;
  logic             out_valid;
  logic             out_ready;
  logic [W*H-1:0]   out_board;
  logic             out_collision;
  logic             busy;

  piece_blit_engine dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_board      (in_board),
    .in_piece      (in_piece),
    .in_x          (in_x),
    .in_y          (in_y),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_board     (out_board),
    .out_collision (out_collision),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W*H-1:0] board;
    logic           coll;
    int             acc;
    int             hold;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk_vec(input string name, input logic [W*H-1:0] got,
                         input logic [W*H-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic chk_bit(input string name, input logic got,
                         input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic logic [W*H-1:0] rand_board(input int dens);
    logic [W*H-1:0] r;
    for (int i = 0; i < W*H; i++)
      r[i] = (int'($urandom_range(0, 99)) < dens);
    return r;
  endfunction

  // Reference: walk every set piece cell on a 2-D board view.
  task automatic model(input int mode, input logic [W*H-1:0] b,
                       input logic [N*N-1:0] p, input int x, input int y,
                       output logic [W*H-1:0] nb, output logic coll);
    nb = b;
    coll = 1'b0;
    for (int dx = 0; dx < N; dx++) begin
      for (int dy = 0; dy < N; dy++) begin
        if (p[dx*N+dy]) begin
          int cx = x + dx;
          int cy = y + dy;
          if (cy >= 0) begin
            if (cx < 0 || cx >= W || cy >= H) begin
              coll = 1'b1;
            end else begin
              if (b[cx*H+cy]) coll = 1'b1;
              if (mode == 0) nb[cx*H+cy] = 1'b1;
              else if (mode == 1) nb[cx*H+cy] = 1'b0;
            end
          end
        end
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    ok = in_ready;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout in_ready=0 want 1");
    end
  endtask

  task automatic scramble();
    in_board = rand_board(50);
    in_piece = 16'($urandom);
    in_x = 6'($urandom);
    in_y = 6'($urandom);
    in_mode = 2'($urandom);
  endtask

  task automatic send(input int mode, input logic [W*H-1:0] b,
                      input logic [N*N-1:0] p, input int x, input int y,
                      input int hold, output logic [W*H-1:0] res);
    exp_t e;
    bit ok;
    res = b;
    wait_ready(ok);
    if (!ok) return;
    in_mode = 2'(mode);
    in_board = b;
    in_piece = p;
    in_x = 6'(x);
    in_y = 6'(y);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    model(mode, b, p, x, y, e.board, e.coll);
    e.acc = cyc;
    e.hold = hold;
    q.push_back(e);
    res = e.board;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
    end
  endtask

  initial begin : monitor
    exp_t cur;
    int stall;
    bit active;
    stall = 0;
    active = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (!active) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result out_valid=1 want 0");
            out_ready = 1'b1;
            continue;
          end
          cur = q[0];
          active = 1;
          stall = cur.hold;
          chk_int("latency", cyc - cur.acc, LAT);
        end
        chk_vec("out_board", out_board, cur.board);
        chk_bit("out_collision", out_collision, cur.coll);
        chk_bit("in_ready_in_done", in_ready, 1'b0);
        if (stall > 0) begin
          stall--;
          out_ready = 1'b0;
        end else begin
          out_ready = 1'b1;
          void'(q.pop_front());
          active = 0;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin : driver
    logic [W*H-1:0] r;
    logic [W*H-1:0] base;
    logic [N*N-1:0] p;
    logic c;
    bit ok;

    reset = 1'b1;
    in_valid = 1'b0;
    in_mode = '0;
    in_board = '0;
    in_piece = '0;
    in_x = '0;
    in_y = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_bit("in_ready_during_reset", in_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_collision", out_collision, 1'b0);
    chk_vec("rst_board", out_board, '0);
    chk_bit("rst_in_ready", in_ready, 1'b1);

    // 2x2 block near the floor, then one row lower into the floor.
    send(0, '0, 16'h0033, 4, 18, 0, r);
    base = rand_board(30);
    send(2, base, 16'h0033, 4, 19, 1, r);
    // Left wall, then flush against it.
    send(2, '0, 16'h000F, -1, 5, 0, r);
    send(2, '0, 16'h000F, 0, 5, 0, r);
    // Right wall: column dx=3 lands on x=10.
    send(2, '0, 16'hF000, 7, 5, 0, r);
    // Spawn zone: only the two lower cells reach the board.
    send(0, '0, 16'h000F, 0, -2, 0, r);

    // Overlay then erase on a board with the piece footprint clear.
    p = 16'h0272;
    base = rand_board(35);
    model(1, base, p, 3, 7, base, c);
    send(0, base, p, 3, 7, 0, r);
    send(1, r, p, 3, 7, 3, r);

    // Reset while scanning column 2 discards the request.
    drain(40);
    wait_ready(ok);
    if (ok) begin
      in_mode = 2'd0;
      in_board = rand_board(40);
      in_piece = 16'hFFFF;
      in_x = 6'd2;
      in_y = 6'd3;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_bit("midrst_out_valid", out_valid, 1'b0);
      chk_bit("midrst_in_ready", in_ready, 1'b1);
      chk_bit("midrst_busy", busy, 1'b0);
      chk_vec("midrst_board", out_board, '0);
    end
    send(0, rand_board(25), 16'h0660, 2, 3, 0, r);

    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 3)),
           rand_board(int'($urandom_range(0, 60))),
           16'($urandom) & 16'($urandom),
           int'($urandom_range(0, 14)) - 3,
           int'($urandom_range(0, 26)) - 5,
           int'($urandom_range(0, 2)), r);
    end

    drain(200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
